fir_mac_engine: RTL
===================

Name: fir_mac_engine

Overview:
- Downstream consumer of the dual-clock sample FIFO; runs entirely in the FIFO read-clock domain.
- Pops one signed sample at a time from the FIFO read port and stores it in a circular delay line.
- Computes one NTAPS-tap FIR output sample using a single time-multiplexed multiply-accumulate, one tap per cycle.
- Presents each result on a valid/ready output port to the next stage.

Parameters:
- DWIDTH, 16, sample width (matches FIFO DWIDTH), signed two's complement
- CWIDTH, 16, coefficient width, signed two's complement
- LOG2_NTAPS, 4, log2 of tap count; NTAPS = 1<<LOG2_NTAPS
- OWIDTH, DWIDTH+CWIDTH+LOG2_NTAPS, accumulator/output width, signed

Ports:
- rd_clk  in  1  block clock (FIFO read clock)
- areset_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_q  in  DWIDTH  FIFO read data, valid the cycle after fifo_read
- fifo_read  out  1  FIFO pop strobe, single-cycle pulse
- coef_we  in  1  coefficient write enable
- coef_addr  in  LOG2_NTAPS  coefficient index k
- coef_data  in  CWIDTH  coefficient value c[k]
- busy  out  1  high in any state other than IDLE
- dout  out  OWIDTH  filter output y[n]
- dout_valid  out  1  output valid
- dout_ready  in  1  downstream accept

Behaviour:
- Single clock. Reset is asynchronous and active-low, named areset_n; the clock is rd_clk.
- Reset values:
  - fifo_read=0, dout=0, dout_valid=0, busy=0.
  - All delay-line entries=0, all coefficients=0.
  - Head pointer=0, tap counter=0, accumulator=0, state=IDLE.
- States: IDLE, LOAD, MAC.
- IDLE:
  - If fifo_empty==0 and (dout_valid==0 or dout_ready==1), assert fifo_read for exactly this cycle and go to LOAD.
  - Otherwise stay in IDLE with fifo_read=0.
  - fifo_read is never asserted while fifo_empty=1.
- LOAD:
  - Write fifo_q into delay line at head.
  - newest <= head; head <= head+1, wrapping mod NTAPS.
  - acc <= 0; k <= 0; go to MAC.
- MAC, NTAPS cycles, k = 0..NTAPS-1:
  - acc <= acc + c[k]*x[(newest-k) mod NTAPS].
  - Product is full DWIDTH+CWIDTH signed, sign-extended to OWIDTH; no rounding, no saturation.
  - Overflow is impossible by construction of OWIDTH.
  - On k==NTAPS-1: dout <= final sum, dout_valid <= 1, go to IDLE.
- Output handshake:
  - A transfer occurs in a cycle with dout_valid && dout_ready.
  - dout is held stable while dout_valid=1 and dout_ready=0.
  - dout_valid clears after a transfer unless a new result is loaded in the same cycle.
- Latency: fifo_read in cycle T gives dout_valid high in cycle T+NTAPS+2.
- Throughput: with dout_ready tied high and the FIFO never empty, one output per NTAPS+2 cycles; fifo_read pulses every NTAPS+2 cycles.
- Coefficient writes:
  - Accepted in any state; c[coef_addr] is updated on the next edge.
  - A write during MAC affects only taps read after the write edge, so the result for that sample is mixed.
  - Software must write only while busy=0.
- Simultaneous events:
  - In IDLE with dout_valid=1 and dout_ready=1: the old result transfers and the new fifo_read issues in the same cycle.
  - coef_we in the same cycle as fifo_read is legal.
- Delay-line wrap: head wraps NTAPS-1 -> 0. Tap addressing is modulo NTAPS. Entries older than NTAPS samples are overwritten.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A sample popped but not yet output is lost; the FIFO pointer has already advanced, and this is accepted behaviour.
  - The delay-line history is cleared.
- Start-up: the first NTAPS-1 outputs use zero history, which is the true FIR transient.

Decomposition:
- Package fir_pkg holds:
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, MAC=2'd2)
  - default width constants for DWIDTH, CWIDTH and LOG2_NTAPS
  - the OWIDTH derivation
- One sub-module, fir_mac:
  - combinational signed DWIDTH x CWIDTH multiply, sign-extended and added to the OWIDTH accumulator input
  - accumulator register with a synchronous clear and an enable
- The state machine, delay line, coefficient registers and handshake stay in fir_mac_engine.

Test Plan:
- Impulse: load c[k]=k+1 (1..16); feed 1 followed by 15 zeros, dout_ready=1 -> dout sequence 1,2,...,16; each dout_valid is NTAPS+2=18 cycles after its fifo_read.
- Step: all c[k]=1; feed 20 samples of 100 -> outputs 100,200,...,1600, then 1600 held for the remaining 4 outputs.
- Extremes: all c[k]=-32768; feed 16 samples of -32768 -> 16th output = +17179869184 (2^34), correct in 36-bit signed with no wrap.
- Backpressure/empty:
  - Hold dout_ready=0 after the first result -> dout stable, no further fifo_read even with the FIFO non-empty.
  - Raise dout_ready -> transfer and a new fifo_read in the same cycle.
  - With fifo_empty=1 throughout -> fifo_read never asserts.
- Reset mid-MAC: assert areset_n=0 at k=7 -> dout_valid=0, busy=0, dout=0 immediately. The next impulse input gives c[0] as the first output, with the history cleared.
- Coefficient update while idle: change c[0] 1 -> 5 with busy=0; feed 3 -> dout=15.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine.
//   state_t        : engine state encoding (IDLE/LOAD/MAC)
//   *_DEF          : default sample, coefficient and tap-count widths
//   owidth_f       : accumulator width that cannot overflow for a given
//                    sample width, coefficient width and tap count
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2
  } state_t;

  localparam int DWIDTH_DEF     = 16;
  localparam int CWIDTH_DEF     = 16;
  localparam int LOG2_NTAPS_DEF = 4;

  // Summing 2^l2 full-width products needs l2 extra bits of headroom.
  function automatic int owidth_f(input int dw, input int cw, input int l2);
    return dw + cw + l2;
  endfunction

  localparam int OWIDTH_DEF = owidth_f(DWIDTH_DEF, CWIDTH_DEF, LOG2_NTAPS_DEF);

endpackage

// File: rtl/fir_mac_engine_mac.sv
// Single multiply-accumulate slice for the FIR engine.
// Ports:
//   rd_clk, areset_n : clock and asynchronous active-low reset
//   clr              : synchronous accumulator clear (wins over en)
//   en               : accumulate sum into acc this cycle
//   x, c             : signed sample and coefficient
//   acc              : accumulator register
//   sum              : acc + sign-extended x*c (combinational)
module fir_mac #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int OWIDTH = 36
) (
  input  logic              rd_clk,
  input  logic              areset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DWIDTH-1:0] x,
  input  logic [CWIDTH-1:0] c,
  output logic [OWIDTH-1:0] acc,
  output logic [OWIDTH-1:0] sum
);

  localparam int PWIDTH = DWIDTH + CWIDTH;

  logic signed [PWIDTH-1:0] prod;

  assign prod = $signed(x) * $signed(c);
  assign sum  = acc + {{(OWIDTH-PWIDTH){prod[PWIDTH-1]}}, prod};

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// NTAPS-tap FIR filter fed from a FIFO read port, one tap per cycle.
//
//   state | meaning
//   IDLE  | waiting for a sample and room on the output; pops the FIFO
//   LOAD  | popped sample arrives, written to the delay line at head
//   MAC   | NTAPS accumulate cycles, result posted on the last one
//
// Ports:
//   rd_clk, areset_n     : FIFO read clock, asynchronous active-low reset
//   fifo_empty, fifo_q   : FIFO status and read data (valid cycle after pop)
//   fifo_read            : single-cycle FIFO pop strobe
//   coef_we/addr/data    : coefficient register write port
//   busy                 : engine not in IDLE
//   dout, dout_valid     : filter output, valid/ready handshake
//   dout_ready           : downstream accept
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int CWIDTH     = CWIDTH_DEF,
  parameter int LOG2_NTAPS = LOG2_NTAPS_DEF,
  parameter int OWIDTH     = owidth_f(DWIDTH, CWIDTH, LOG2_NTAPS)
) (
  input  logic                  rd_clk,
  input  logic                  areset_n,
  input  logic                  fifo_empty,
  input  logic [DWIDTH-1:0]     fifo_q,
  output logic                  fifo_read,
  input  logic                  coef_we,
  input  logic [LOG2_NTAPS-1:0] coef_addr,
  input  logic [CWIDTH-1:0]     coef_data,
  output logic                  busy,
  output logic [OWIDTH-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int NTAPS = 1 << LOG2_NTAPS;

  state_t                state, state_nxt;
  logic [LOG2_NTAPS-1:0] head, newest, k, tap_idx;
  logic [DWIDTH-1:0]     dline [NTAPS];
  logic [CWIDTH-1:0]     coef  [NTAPS];
  logic                  pop, mac_clr, mac_en, last_tap;
  logic [OWIDTH-1:0]     acc, sum;

  assign last_tap = (k == LOG2_NTAPS'(NTAPS - 1));
  // Natural wrap of the LOG2_NTAPS-bit subtraction gives the modulo index.
  assign tap_idx  = newest - k;
  assign busy     = (state != IDLE);
  // Gated by reset so no pop can escape while the engine is held in reset.
  assign fifo_read = pop & areset_n;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!dout_valid || dout_ready)) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        mac_clr   = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      state  <= IDLE;
      head   <= '0;
      newest <= '0;
      k      <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        newest <= head;
        head   <= head + 1'b1;
        k      <= '0;
      end else if (state == MAC) begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else if (state == LOAD) begin
      dline[head] <= fifo_q;
    end
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH),
    .OWIDTH(OWIDTH)
  ) u_mac (
    .rd_clk  (rd_clk),
    .areset_n(areset_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .x       (dline[tap_idx]),
    .c       (coef[k]),
    .acc     (acc),
    .sum     (sum)
  );

  // The final tap's product is folded in via sum, so the result is
  // posted on the same edge that completes the last accumulate.
  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (state == MAC && last_tap) begin
      dout       <= sum;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
